// File: rtl/pixel_scan_scheduler.sv
// pixel_scan_scheduler: raster read sequencer for the banked pixel store, sharing its read port with a host
// Ports: clk50/rst (sync, active-high); start/abort frame control; ds_ready downstream backpressure;
//   host_req + host_bank/row/col host read request, host_gnt one-cycle grant;
//   mem_rd/mem_bank/mem_row/mem_col/mem_sel store read port (mem_sel=1 when the host owns the read);
//   pix_row/pix_col/sol/eol scan position of the current read; scan_vld store data valid;
//   busy (not IDLE) and frame_done one-cycle end-of-frame pulse.
module pixel_scan_scheduler #(
   parameter int COLS          = 1448,
   parameter int ROWS          = 1072,
   parameter int ROWS_PER_BANK = 67,
   parameter int BANKS         = 16,
   parameter int HBLANK        = 8
) (
   input  logic        clk50,
   input  logic        rst,
   input  logic        start,
   input  logic        abort,
   input  logic        ds_ready,
   input  logic        host_req,
   input  logic [3:0]  host_bank,
   input  logic [6:0]  host_row,
   input  logic [11:0] host_col,
   output logic        host_gnt,
   output logic        mem_rd,
   output logic [3:0]  mem_bank,
   output logic [6:0]  mem_row,
   output logic [11:0] mem_col,
   output logic        mem_sel,
   output logic [11:0] pix_row,
   output logic [11:0] pix_col,
   output logic        sol,
   output logic        eol,
   output logic        scan_vld,
   output logic        busy,
   output logic        frame_done
);
   localparam logic [11:0] COL_LAST  = 12'(COLS - 1);
   localparam logic [11:0] ROW_LAST  = 12'(ROWS - 1);
   localparam logic [6:0]  BROW_LAST = 7'(ROWS_PER_BANK - 1);
   localparam logic [3:0]  BANK_LAST = 4'(BANKS - 1);
   localparam int          BW        = $clog2(HBLANK + 1);
   localparam logic [BW-1:0] BLANK_LAST = BW'(HBLANK - 1);

   typedef enum logic [1:0] {IDLE, SCAN, BLANK, DONE} state_t;

   state_t        st;
   logic [11:0]   row, col, hcol;
   logic [6:0]    bank_row, hrow;
   logic [3:0]    bank, hbank;
   logic [BW-1:0] blank;
   logic          scan_rd, line_end, gnt_ok;

   assign scan_rd  = st == SCAN && ds_ready;
   assign line_end = scan_rd && col == COL_LAST;
   // The grant is registered, so decide it one cycle early: it must land in an IDLE cycle
   // or a blank cycle, never in the cycle the next line restarts.
   assign gnt_ok = host_req && !host_gnt &&
                   ((st == IDLE && !start) || (line_end && row != ROW_LAST) ||
                    (st == BLANK && blank != BLANK_LAST));

   always_ff @(posedge clk50) begin
      if (rst || abort) begin
         st         <= IDLE;
         row        <= '0;
         col        <= '0;
         bank       <= '0;
         bank_row   <= '0;
         blank      <= '0;
         host_gnt   <= 1'b0;
         hbank      <= '0;
         hrow       <= '0;
         hcol       <= '0;
         frame_done <= 1'b0;
      end else begin
         host_gnt   <= gnt_ok;
         frame_done <= line_end && row == ROW_LAST;
         if (gnt_ok) begin
            hbank <= host_bank;
            hrow  <= host_row;
            hcol  <= host_col;
         end
         case (st)
            IDLE: if (start) begin
               st       <= SCAN;
               row      <= '0;
               col      <= '0;
               bank     <= '0;
               bank_row <= '0;
               blank    <= '0;
            end
            SCAN: if (line_end) begin
               if (row == ROW_LAST) st <= DONE;
               else begin
                  st       <= BLANK;
                  blank    <= '0;
                  col      <= '0;
                  row      <= row + 12'd1;
                  bank_row <= bank_row == BROW_LAST ? '0 : bank_row + 7'd1;
                  if (bank_row == BROW_LAST) bank <= bank == BANK_LAST ? '0 : bank + 4'd1;
               end
            end else if (scan_rd) col <= col + 12'd1;
            BLANK: begin
               blank <= BW'(blank + 1);
               if (blank == BLANK_LAST) st <= SCAN;
            end
            default: st <= IDLE;
         endcase
      end
   end

   // Data for a scan read issued in the abort cycle still arrives, so only rst clears this.
   always_ff @(posedge clk50) scan_vld <= rst ? 1'b0 : scan_rd;

   assign mem_rd   = scan_rd || host_gnt;
   assign mem_sel  = host_gnt;
   assign mem_bank = host_gnt ? hbank : bank;
   assign mem_row  = host_gnt ? hrow : bank_row;
   assign mem_col  = host_gnt ? hcol : col;
   assign pix_row  = row;
   assign pix_col  = col;
   assign sol      = scan_rd && col == '0;
   assign eol      = line_end;
   assign busy     = st != IDLE;
endmodule

// File: tb/tb_pixel_scan_scheduler.sv
// tb_pixel_scan_scheduler: directed vector table plus frame, stall, host and abort/reset sequences
module tb_pixel_scan_scheduler;
   localparam int C = 10, R = 12, RPB = 3, NB = 4, HB = 4, STALL = 5;

   logic        clk50 = 1'b0;
   logic        rst = 1'b1, start = 1'b0, abort = 1'b0, ds_ready = 1'b0, host_req = 1'b0;
   logic [3:0]  host_bank = '0;
   logic [6:0]  host_row = '0;
   logic [11:0] host_col = '0;
   logic        host_gnt, mem_rd, mem_sel, sol, eol, scan_vld, busy, frame_done;
   logic [3:0]  mem_bank;
   logic [6:0]  mem_row;
   logic [11:0] mem_col, pix_row, pix_col;
   logic [54:0] obs;

   always #5 clk50 = ~clk50;

   pixel_scan_scheduler #(.COLS(C), .ROWS(R), .ROWS_PER_BANK(RPB), .BANKS(NB), .HBLANK(HB)) dut (
      .clk50(clk50), .rst(rst), .start(start), .abort(abort), .ds_ready(ds_ready),
      .host_req(host_req), .host_bank(host_bank), .host_row(host_row), .host_col(host_col),
      .host_gnt(host_gnt), .mem_rd(mem_rd), .mem_bank(mem_bank), .mem_row(mem_row),
      .mem_col(mem_col), .mem_sel(mem_sel), .pix_row(pix_row), .pix_col(pix_col),
      .sol(sol), .eol(eol), .scan_vld(scan_vld), .busy(busy), .frame_done(frame_done)
   );

   assign obs = {host_gnt, mem_rd, mem_sel, mem_bank, mem_row, mem_col, pix_row, pix_col,
                 sol, eol, scan_vld, busy, frame_done};

   typedef struct {
      string       name;
      logic [4:0]  ctl;   // {rst, start, abort, ds_ready, host_req}
      logic [3:0]  hb;
      logic [6:0]  hr;
      logic [11:0] hc;
      logic [54:0] exp;
   } vec_t;

   vec_t tbl[12];
   int vecs = 0, miss = 0;

   // {gnt,rd,sel}, bank, bank_row, col, pix_row, pix_col, {sol,eol,vld,busy,done}
   function automatic logic [54:0] o(logic [2:0] gsr, logic [3:0] b, logic [6:0] r, logic [11:0] c,
                                     logic [11:0] pr, logic [11:0] pc, logic [4:0] f);
      return {gsr, b, r, c, pr, pc, f};
   endfunction

   function automatic vec_t v(string n, logic [4:0] ctl, logic [3:0] hb, logic [6:0] hr,
                              logic [11:0] hc, logic [54:0] e);
      vec_t t;
      t.name = n; t.ctl = ctl; t.hb = hb; t.hr = hr; t.hc = hc; t.exp = e;
      return t;
   endfunction

   task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
      vecs++;
      if (act !== exp) begin
         miss++;
         $display("FAIL %s: got %0h, want %0h", n, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk50);
      #1;
   endtask

   task automatic midframe(input bit use_rst);
      int n;
      start = 1'b1; ds_ready = 1'b1; host_req = 1'b0;
      #2; tick; start = 1'b0;
      n = 0;
      #2;
      while (!(mem_rd && !mem_sel && pix_row == 12'd5) && n < 200) begin
         tick; #2; n++;
      end
      chk(use_rst ? "rst_reach_row5" : "abort_reach_row5", 64'(n < 200), 64'(1));
      if (use_rst) rst = 1'b1; else abort = 1'b1;
      tick; rst = 1'b0; abort = 1'b0;
      #2;
      if (use_rst) chk("rst_mid_clear", 64'(obs), 64'(0));
      else chk("abort_mid_clear", 64'({busy, mem_rd, frame_done, pix_row, pix_col}), 64'(0));
      for (int i = 0; i < 10; i++) begin
         tick; #2;
         chk("no_done_after_stop", 64'({frame_done, busy, mem_rd}), 64'(0));
      end
      start = 1'b1;
      tick; start = 1'b0;
      #2;
      chk("restart_first_read",
          64'({mem_rd, mem_sel, mem_bank, mem_row, mem_col, pix_row, pix_col, sol, busy}),
          64'({2'b10, 4'd0, 7'd0, 12'd0, 12'd0, 12'd0, 1'b1, 1'b1}));
      abort = 1'b1;
      tick; abort = 1'b0;
   endtask

   int er, ec, gap, gnt_exp, gnts, stall_left, exp_last;
   bit fin, rd_prev, exp_rd, stalled, req_a, req_b;
   logic [48:0] exp_addr;

   initial begin
      tbl[0]  = v("reset_state",    5'b00010, 4'd0, 7'd0,  12'd0,    o(3'b000, 4'd0, 7'd0,  12'd0,    12'd0, 12'd0, 5'b00000));
      tbl[1]  = v("host_req_idle",  5'b00011, 4'd5, 7'd66, 12'd1447, o(3'b000, 4'd0, 7'd0,  12'd0,    12'd0, 12'd0, 5'b00000));
      tbl[2]  = v("host_gnt_idle",  5'b00011, 4'd5, 7'd66, 12'd1447, o(3'b111, 4'd5, 7'd66, 12'd1447, 12'd0, 12'd0, 5'b00000));
      tbl[3]  = v("host_gnt_once",  5'b00010, 4'd0, 7'd0,  12'd0,    o(3'b000, 4'd0, 7'd0,  12'd0,    12'd0, 12'd0, 5'b00000));
      tbl[4]  = v("start_and_hreq", 5'b01011, 4'd3, 7'd1,  12'd2,    o(3'b000, 4'd0, 7'd0,  12'd0,    12'd0, 12'd0, 5'b00000));
      tbl[5]  = v("first_read",     5'b00010, 4'd0, 7'd0,  12'd0,    o(3'b010, 4'd0, 7'd0,  12'd0,    12'd0, 12'd0, 5'b10010));
      tbl[6]  = v("scan_hreq",      5'b00011, 4'd3, 7'd1,  12'd2,    o(3'b010, 4'd0, 7'd0,  12'd1,    12'd0, 12'd1, 5'b00110));
      tbl[7]  = v("stall",          5'b00001, 4'd3, 7'd1,  12'd2,    o(3'b000, 4'd0, 7'd0,  12'd2,    12'd0, 12'd2, 5'b00110));
      tbl[8]  = v("resume",         5'b00011, 4'd3, 7'd1,  12'd2,    o(3'b010, 4'd0, 7'd0,  12'd2,    12'd0, 12'd2, 5'b00010));
      tbl[9]  = v("abort_cycle",    5'b00100, 4'd0, 7'd0,  12'd0,    o(3'b000, 4'd0, 7'd0,  12'd3,    12'd0, 12'd3, 5'b00110));
      tbl[10] = v("after_abort",    5'b00010, 4'd0, 7'd0,  12'd0,    o(3'b000, 4'd0, 7'd0,  12'd0,    12'd0, 12'd0, 5'b00000));
      tbl[11] = v("idle_quiet",     5'b00000, 4'd0, 7'd0,  12'd0,    o(3'b000, 4'd0, 7'd0,  12'd0,    12'd0, 12'd0, 5'b00000));

      repeat (2) @(posedge clk50);
      #1;
      for (int i = 0; i < 12; i++) begin
         {rst, start, abort, ds_ready, host_req} = tbl[i].ctl;
         host_bank = tbl[i].hb; host_row = tbl[i].hr; host_col = tbl[i].hc;
         #2;
         chk(tbl[i].name, 64'(obs), 64'(tbl[i].exp));
         tick;
      end

      // Full frame: one 5-cycle stall at row 5 col 7, host request at an eol and one mid-line.
      er = 0; ec = 0; gap = 0; fin = 0; rd_prev = 0; gnt_exp = -1; gnts = 0;
      stall_left = 0; stalled = 0; req_a = 0; req_b = 0;
      exp_last = (R - 1) * (C + HB) + C + STALL;
      start = 1'b1; ds_ready = 1'b1; host_req = 1'b0;
      #2; tick; start = 1'b0;
      for (int cyc = 1; cyc <= exp_last + 2; cyc++) begin
         if (!stalled && er == 5 && ec == 7) begin stall_left = STALL; stalled = 1; end
         ds_ready = stall_left == 0;
         if (!req_a && er == 2 && ec == C - 1) begin
            req_a = 1; host_req = 1'b1; host_bank = 4'hA; host_row = 7'd33; host_col = 12'd999;
         end
         if (!req_b && er == 7 && ec == 3) begin
            req_b = 1; host_req = 1'b1; host_bank = 4'h2; host_row = 7'd66; host_col = 12'd1447;
         end
         exp_rd = ds_ready && gap == 0 && !fin;
         #2;
         chk("scan_rd", 64'(mem_rd & ~mem_sel), 64'(exp_rd));
         chk("scan_vld", 64'(scan_vld), 64'(rd_prev));
         chk("frame_done", 64'(frame_done), 64'(cyc == exp_last + 1));
         chk("busy", 64'(busy), 64'(cyc <= exp_last + 1));
         chk("host_gnt", 64'(host_gnt), 64'(cyc == gnt_exp));
         if (host_gnt) begin
            gnts++;
            chk("host_bus", 64'({mem_rd, mem_sel, mem_bank, mem_row, mem_col}),
                64'({2'b11, host_bank, host_row, host_col}));
            host_req = 1'b0;
         end
         if (exp_rd) begin
            exp_addr = {4'(er / RPB), 7'(er % RPB), 12'(ec), 12'(er), 12'(ec), ec == 0, ec == C - 1};
            chk("scan_addr", 64'({mem_bank, mem_row, mem_col, pix_row, pix_col, sol, eol}), 64'(exp_addr));
            if (ec == C - 1) begin
               if (host_req) gnt_exp = cyc + 1;
               if (er == R - 1) fin = 1;
               else begin gap = HB; ec = 0; er++; end
            end else ec++;
         end else if (gap > 0) gap--;
         if (stall_left > 0) stall_left--;
         rd_prev = exp_rd;
         tick;
      end
      chk("host_gnt_count", 64'(gnts), 64'(2));

      midframe(1'b0);
      midframe(1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
      $finish;
   end
endmodule

// File: doc/pixel_scan_scheduler.md
# pixel_scan_scheduler

Sequences raster reads from the 16-bank pixel parameter store (1448 x 1072 pixels, 67 rows per bank, one 96-bit L/A/B word per pixel). It also shares the store's single read port with a host requester. The scan side produces bank/row/column addresses incrementally, with no division, and honours downstream backpressure. Host reads are granted only when no scan read is issued: while idle and during the inter-line blanking gap.

## Interface
Parameters:
- COLS, 1448, pixels per line
- ROWS, 1072, lines per frame
- ROWS_PER_BANK, 67, lines held in each bank
- BANKS, 16, number of banks (ROWS = BANKS * ROWS_PER_BANK)
- HBLANK, 8, idle cycles inserted after every line except the last

Ports:
- clk50  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- start  in  1  begin a frame; sampled only in IDLE
- abort  in  1  terminate the frame; IDLE on the next cycle
- ds_ready  in  1  downstream can accept a pixel; low stalls the scan
- host_req  in  1  host read request, held until granted
- host_bank  in  4  host bank index
- host_row  in  7  host row within bank (0..66)
- host_col  in  12  host column (0..1447)
- host_gnt  out  1  one-cycle grant; the address is on the mem bus in that same cycle
- mem_rd  out  1  read strobe to the pixel store
- mem_bank  out  4  bank select
- mem_row  out  7  row within bank
- mem_col  out  12  column
- mem_sel  out  1  0 = scan owns the current read, 1 = host owns it
- pix_row  out  12  global row of the current scan read
- pix_col  out  12  global column of the current scan read
- sol  out  1  the scan read is column 0
- eol  out  1  the scan read is column COLS-1
- scan_vld  out  1  store data for the previous-cycle scan read is valid now
- busy  out  1  high in every state except IDLE
- frame_done  out  1  one-cycle pulse after the last pixel is issued

## Operation
- States: IDLE, SCAN, HBLANK, DONE.
- IDLE: if start=1, clear row, col, bank, bank_row and go to SCAN. Otherwise serve a pending host_req.
- SCAN, each cycle with ds_ready=1:
  - Assert mem_rd with mem_sel=0 and present {bank, bank_row, col}.
  - Then advance col.
  - sol and eol are combinational decodes of the issued column.
- SCAN with ds_ready=0: mem_rd=0, all counters hold, no host grant.
- Issue at col=COLS-1:
  - If row<ROWS-1: col←0, row←row+1, then go to HBLANK.
  - If row=ROWS-1: go to DONE.
- bank_row advance at end of line: if bank_row=ROWS_PER_BANK-1, set bank_row←0 and bank←bank+1; else bank_row←bank_row+1.
- HBLANK: count HBLANK cycles, then return to SCAN. A host grant may occur in any blank cycle; the blank counter runs regardless.
- DONE: frame_done=1 for one cycle, then IDLE.
- Host arbitration:
  - Grant only in IDLE or HBLANK when host_req=1.
  - On grant: host_gnt=1, mem_rd=1, mem_sel=1, mem bus = host fields.
  - At most one grant per cycle.
  - Scan reads always have priority, so a host read is never granted in SCAN.
- scan_vld is mem_rd & ~mem_sel registered by one cycle.
- abort (any state): IDLE on the next cycle, no frame_done, counters cleared.
- start while busy: ignored.
- Simultaneous start and host_req in IDLE: start wins and no grant is issued.
- Out-of-range host fields are passed through unchecked; range checking is the host's responsibility.

## Timing
- Reset values: all outputs 0; state IDLE; counters 0.
- Reset mid-frame clears everything within the cycle it is sampled.
- Latency: start at cycle t → first scan read (row 0, col 0, sol=1) at t+1 → scan_vld at t+2.
- Stall-free line: COLS consecutive reads followed by exactly HBLANK blank cycles.
- Stall-free frame from start at cycle 0:
  - Last read (row 1071, col 1447, bank 15, bank_row 66, eol=1) at cycle 1,560,824.
  - frame_done at cycle 1,560,825; busy drops at cycle 1,560,826.
- Host grant latency: 1 cycle from host_req in IDLE (registered state).
- pix_row and pix_col are 12-bit and never exceed ROWS-1 and COLS-1.

## Test plan
- Stall-free frame, default parameters: start at cycle 0 → 1,552,256 scan reads; frame_done at cycle 1,560,825; 1071 blank gaps of 8 cycles each.
- Bank boundary: scan through row 66 → row 67 reads present bank 1, bank_row 0; row 1005 → bank 15, bank_row 0.
- Backpressure: ds_ready=0 for 5 cycles at col 700 → mem_rd low for those 5 cycles; resume at col 700 with no skip or duplicate.
- Host in blank gap: host_req held from the eol cycle → host_gnt in the first HBLANK cycle with mem_sel=1; gap length stays 8; next line starts on time.
- Host while scanning: host_req during SCAN → no grant until HBLANK; host_req with start in IDLE → scan starts, no grant.
- Abort/reset mid-frame: abort at row 300 → IDLE next cycle, busy=0, frame_done never pulses; then start → row 0, col 0. rst at row 300 behaves the same.
